// File: rtl/chord_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : chord_voice_scheduler
// Brief    : Per-sample sequencer that allocates eight keys onto phase-
//            accumulator voices, shares one increment lookup and one wavetable
//            port between them, and mixes the voices into an 8-bit sample.
// Revision : 1.0 - initial release
// ============================================================================
module chord_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  t0,
    input  logic                  t1,
    input  logic                  t2,
    input  logic                  t3,
    input  logic                  t4,
    input  logic                  t5,
    input  logic                  t6,
    input  logic                  t7,
    output logic [2:0]            inc_key,
    input  logic [PHASE_W-1:0]    inc_val,
    output logic                  rom_req,
    output logic [7:0]            rom_addr,
    input  logic                  rom_ack,
    input  logic [7:0]            rom_data,
    output logic [7:0]            wave,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);

    localparam int c_vw    = $clog2(NUM_VOICES);
    localparam int c_acc_w = 8 + c_vw;
    localparam int c_cnt_w = $clog2(SAMPLE_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LISTEN   = 3'd1,
        S_GET_FREQ = 3'd2,
        S_READ     = 3'd3,
        S_SUM      = 3'd4,
        S_PLAY     = 3'd5
    } state_t;

    state_t                               state_q, state_d;
    logic [c_cnt_w-1:0]                   cnt_q, cnt_d;
    logic                                 pending_q, pending_d;
    logic                                 overrun_q, overrun_d;
    logic [7:0]                           key_meta_q, key_meta_d;
    logic [7:0]                           key_sync_q, key_sync_d;
    logic [NUM_VOICES-1:0]                active_q, active_d;
    logic [NUM_VOICES-1:0][2:0]           vkey_q, vkey_d;
    logic [NUM_VOICES-1:0][PHASE_W-1:0]   phase_q, phase_d;
    logic [3:0]                           step_q, step_d;
    logic [c_acc_w-1:0]                   acc_q, acc_d;
    logic [7:0]                           sum_q, sum_d;
    logic [7:0]                           wave_q, wave_d;
    logic                                 rom_req_q, rom_req_d;
    logic [7:0]                           rom_addr_q, rom_addr_d;

    logic                                 w_tick;
    logic [7:0]                           w_keys;
    logic [2:0]                           w_scan_key;
    logic                                 w_owned;
    logic                                 w_free_found;
    logic [c_vw-1:0]                      w_free_idx;
    logic [c_vw-1:0]                      w_vidx;
    logic [c_vw:0]                        w_n_inact;

    assign w_tick = (cnt_q == c_cnt_last);
    assign w_keys = {t7, t6, t5, t4, t3, t2, t1, t0};

    always_comb begin
        state_d      = state_q;
        cnt_d        = w_tick ? '0 : cnt_q + 1'b1;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        key_meta_d   = w_keys;
        key_sync_d   = key_meta_q;
        active_d     = active_q;
        vkey_d       = vkey_q;
        phase_d      = phase_q;
        step_d       = step_q;
        acc_d        = acc_q;
        sum_d        = sum_q;
        wave_d       = wave_q;
        rom_req_d    = rom_req_q;
        rom_addr_d   = rom_addr_q;
        inc_key      = '0;
        w_scan_key   = 3'(step_q - 4'd1);
        w_vidx       = step_q[c_vw-1:0];
        w_owned      = 1'b0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_n_inact    = '0;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (active_q[v] && (vkey_q[v] == w_scan_key)) w_owned = 1'b1;
            if (!active_q[v]) w_n_inact = w_n_inact + (c_vw+1)'(1);
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_vw'(v);
            end
        end

        // A tick that lands mid-sequence is remembered once; further ticks are lost.
        if (w_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_tick || pending_q) begin
                    pending_d = 1'b0;
                    step_d    = '0;
                    state_d   = S_LISTEN;
                end
            end
            S_LISTEN: begin
                if (step_q == 4'd0) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (active_q[v] && !key_sync_q[vkey_q[v]]) active_d[v] = 1'b0;
                    end
                end else if (key_sync_q[w_scan_key] && !w_owned && w_free_found) begin
                    active_d[w_free_idx] = 1'b1;
                    vkey_d[w_free_idx]   = w_scan_key;
                    phase_d[w_free_idx]  = '0;
                end
                if (step_q == 4'd8) begin
                    step_d  = '0;
                    state_d = S_GET_FREQ;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_GET_FREQ: begin
                if (active_q[w_vidx]) begin
                    inc_key         = vkey_q[w_vidx];
                    phase_d[w_vidx] = phase_q[w_vidx] + inc_val;
                end
                if (step_q == 4'(NUM_VOICES - 1)) begin
                    step_d  = '0;
                    // Silent voices contribute midscale so the mix stays centred.
                    acc_d   = c_acc_w'(w_n_inact) << 7;
                    state_d = S_READ;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_READ: begin
                if (rom_req_q) begin
                    if (rom_ack) begin
                        acc_d     = acc_q + c_acc_w'(rom_data);
                        rom_req_d = 1'b0;
                        step_d    = step_q + 4'd1;
                    end
                end else if (step_q == 4'(NUM_VOICES)) begin
                    state_d = S_SUM;
                end else if (active_q[w_vidx]) begin
                    rom_req_d  = 1'b1;
                    rom_addr_d = phase_q[w_vidx][PHASE_W-1 -: 8];
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_SUM: begin
                sum_d   = acc_q[c_acc_w-1:c_vw];
                state_d = S_PLAY;
            end
            S_PLAY: begin
                wave_d  = sum_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            key_meta_q <= '0;
            key_sync_q <= '0;
            active_q   <= '0;
            vkey_q     <= '0;
            phase_q    <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            sum_q      <= 8'h80;
            wave_q     <= 8'h80;
            rom_req_q  <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            active_q   <= active_d;
            vkey_q     <= vkey_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            wave_q     <= wave_d;
            rom_req_q  <= rom_req_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_req      = rom_req_q;
    assign rom_addr     = rom_addr_q;
    assign wave         = wave_q;
    assign voice_active = active_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_chord_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_chord_voice_scheduler
// Brief    : Directed scoreboard bench for chord_voice_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chord_voice_scheduler;

    localparam int NV   = 4;
    localparam int PW   = 16;
    localparam int SD_A = 1024;
    localparam int SD_B = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] keys;

    logic [2:0]  inc_key_a, inc_key_b;
    logic [15:0] inc_val_a, inc_val_b;
    logic        rom_req_a, rom_req_b, rom_ack_a, rom_ack_b;
    logic [7:0]  rom_addr_a, rom_addr_b, rom_data_a, rom_data_b, wave_a, wave_b;
    logic [3:0]  act_a, act_b;
    logic        ovr_a, ovr_b;

    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] inc_of(input logic [2:0] k);
        case (k)
            3'd0:    inc_of = 16'h0200;
            3'd1:    inc_of = 16'h0500;
            3'd2:    inc_of = 16'h0100;
            3'd3:    inc_of = 16'h0300;
            3'd4:    inc_of = 16'h0700;
            3'd5:    inc_of = 16'h0A00;
            3'd6:    inc_of = 16'h0B00;
            default: inc_of = 16'h0D00;
        endcase
    endfunction

    assign inc_val_a  = inc_of(inc_key_a);
    assign inc_val_b  = inc_of(inc_key_b);
    assign rom_data_a = rom_addr_a;
    assign rom_data_b = rom_addr_b;

    chord_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_DIV(SD_A)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .t0(keys[0]), .t1(keys[1]), .t2(keys[2]), .t3(keys[3]),
        .t4(keys[4]), .t5(keys[5]), .t6(keys[6]), .t7(keys[7]),
        .inc_key(inc_key_a), .inc_val(inc_val_a),
        .rom_req(rom_req_a), .rom_addr(rom_addr_a), .rom_ack(rom_ack_a), .rom_data(rom_data_a),
        .wave(wave_a), .voice_active(act_a), .overrun(ovr_a)
    );

    chord_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_DIV(SD_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .t0(keys[0]), .t1(keys[1]), .t2(keys[2]), .t3(keys[3]),
        .t4(keys[4]), .t5(keys[5]), .t6(keys[6]), .t7(keys[7]),
        .inc_key(inc_key_b), .inc_val(inc_val_b),
        .rom_req(rom_req_b), .rom_addr(rom_addr_b), .rom_ack(rom_ack_b), .rom_data(rom_data_b),
        .wave(wave_b), .voice_active(act_b), .overrun(ovr_b)
    );

    // ROM responder for dut_a: acks after lat_a wait cycles, logs served addresses
    int         lat_a  = 0;
    int         wcnt_a = 0;
    int         stab_a = 0;
    logic       busy_a = 1'b0;
    logic [7:0] held_a = 8'h00;
    logic [7:0] got_a[$];

    assign rom_ack_a = rom_req_a && (wcnt_a == lat_a);

    always @(posedge clk) begin
        if (!rst_n) begin
            wcnt_a <= 0;
            busy_a <= 1'b0;
        end else if (rom_req_a) begin
            if (busy_a && (rom_addr_a !== held_a)) stab_a <= stab_a + 1;
            if (!busy_a) held_a <= rom_addr_a;
            if (rom_ack_a) begin
                got_a.push_back(rom_addr_a);
                busy_a <= 1'b0;
                wcnt_a <= 0;
            end else begin
                busy_a <= 1'b1;
                wcnt_a <= wcnt_a + 1;
            end
        end else begin
            if (busy_a) stab_a <= stab_a + 1;
            wcnt_a <= 0;
        end
    end

    // ROM responder for dut_b: logs request-rise and ack cycle numbers
    int   lat_b   = 0;
    int   wcnt_b  = 0;
    int   cyc     = 0;
    logic prev_b  = 1'b0;
    int   rise_b[$];
    int   ackc_b[$];

    assign rom_ack_b = rom_req_b && (wcnt_b == lat_b);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            wcnt_b <= 0;
            prev_b <= 1'b0;
        end else begin
            prev_b <= rom_req_b;
            if (rom_req_b && !prev_b) rise_b.push_back(cyc);
            if (rom_ack_b) begin
                ackc_b.push_back(cyc);
                wcnt_b <= 0;
            end else if (rom_req_b) begin
                wcnt_b <= wcnt_b + 1;
            end else begin
                wcnt_b <= 0;
            end
        end
    end

    // Reference model of the voice pool
    logic        m_act [NV];
    logic [2:0]  m_key [NV];
    logic [15:0] m_ph  [NV];
    logic [7:0]  exp_addr[$];
    logic [7:0]  exp_wave[$];
    logic [3:0]  exp_act[$];
    int          rd_a     = 0;
    int          base_r   = 0;
    int          base_ack = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 1'b0;
            m_key[v] = 3'd0;
            m_ph[v]  = 16'h0000;
        end
        exp_addr.delete();
        exp_wave.delete();
        exp_act.delete();
    endtask

    task automatic model_period(input logic [7:0] k);
        int         acc;
        int         fv;
        bit         own;
        logic [3:0] a;
        for (int v = 0; v < NV; v++)
            if (m_act[v] && !k[m_key[v]]) m_act[v] = 1'b0;
        for (int kk = 0; kk < 8; kk++) begin
            if (k[kk]) begin
                own = 1'b0;
                for (int v = 0; v < NV; v++)
                    if (m_act[v] && (m_key[v] == 3'(kk))) own = 1'b1;
                if (!own) begin
                    fv = -1;
                    for (int v = NV - 1; v >= 0; v--)
                        if (!m_act[v]) fv = v;
                    if (fv >= 0) begin
                        m_act[fv] = 1'b1;
                        m_key[fv] = 3'(kk);
                        m_ph[fv]  = 16'h0000;
                    end
                end
            end
        end
        acc = 0;
        for (int v = 0; v < NV; v++) begin
            a[v] = m_act[v];
            if (m_act[v]) begin
                m_ph[v] = m_ph[v] + inc_of(m_key[v]);
                exp_addr.push_back(m_ph[v][15:8]);
                acc = acc + int'(m_ph[v][15:8]);
            end else begin
                acc = acc + 128;
            end
        end
        exp_wave.push_back(8'(acc >> 2));
        exp_act.push_back(a);
    endtask

    // Drive keys at offset 900 of a dut_a period, then check at offset 900 of the next
    task automatic run_period(input logic [7:0] k, input string tag);
        keys = k;
        model_period(k);
        repeat (SD_A) @(posedge clk);
        #1;
        chk({tag, " wave"}, 32'(wave_a), 32'(exp_wave.pop_front()));
        chk({tag, " active"}, 32'(act_a), 32'(exp_act.pop_front()));
        chk({tag, " nreq"}, 32'(got_a.size() - rd_a), 32'(exp_addr.size()));
        while (exp_addr.size() > 0 && rd_a < got_a.size()) begin
            chk({tag, " addr"}, 32'(got_a[rd_a]), 32'(exp_addr.pop_front()));
            rd_a++;
        end
        exp_addr.delete();
        rd_a = got_a.size();
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        base_r   = rise_b.size();
        base_ack = ackc_b.size();
        model_reset();
        rd_a = got_a.size();
        repeat (900) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int m;
        int gap;
        rst_n = 1'b0;
        keys  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst wave", 32'(wave_a), 32'h80);
        chk("rst rom_req", 32'(rom_req_a), 32'h0);
        chk("rst rom_addr", 32'(rom_addr_a), 32'h0);
        chk("rst inc_key", 32'(inc_key_a), 32'h0);
        chk("rst active", 32'(act_a), 32'h0);
        chk("rst overrun", 32'(ovr_a), 32'h0);
        chk("rst wave_b", 32'(wave_b), 32'h80);
        @(negedge clk) rst_n = 1'b1;
        repeat (900) @(posedge clk);
        #1;

        // 1: silence
        run_period(8'h00, "t1 p1");
        run_period(8'h00, "t1 p2");

        // 2: single held key, phase walks 0x0100 per period
        run_period(8'h04, "t2 p1");
        run_period(8'h04, "t2 p2");
        run_period(8'h04, "t2 p3");
        chk("t2 rom_addr", 32'(rom_addr_a), 32'h03);
        chk("t2 wave", 32'(wave_a), 32'h60);

        // 3: six keys onto four voices, then release t1
        do_reset();
        run_period(8'h3F, "t3 full");
        chk("t3 all busy", 32'(act_a), 32'hF);
        run_period(8'h3D, "t3 realloc");

        // 4: slow ROM
        lat_a = 5;
        run_period(8'h3D, "t4 p1");
        run_period(8'h3D, "t4 p2");
        chk("t4 req stable", 32'(stab_a), 32'h0);
        chk("t4 overrun_a", 32'(ovr_a), 32'h0);

        // 6: reset asserted while a read is outstanding
        lat_a = 20;
        n = 0;
        while (!rom_req_a && n < 2 * SD_A) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6 req seen", 32'(rom_req_a), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6 req drop", 32'(rom_req_a), 32'h0);
        chk("t6 wave", 32'(wave_a), 32'h80);
        chk("t6 active", 32'(act_a), 32'h0);
        lat_a = 0;
        do_reset();
        chk("t6 free after", 32'(act_a), 32'h0);
        run_period(8'h3D, "t6 post");
        chk("t6 req stable", 32'(stab_a), 32'h0);

        // 5: short period with a slow ROM on dut_b
        chk("t5 no overrun yet", 32'(ovr_b), 32'h0);
        lat_b = 20;
        repeat (800) @(posedge clk);
        #1;
        chk("t5 overrun", 32'(ovr_b), 32'h1);
        m = (rise_b.size() - base_r - 1) / 4;
        chk("t5 enough seqs", 32'(m >= 3), 32'h1);
        if (m >= 1) begin
            gap = rise_b[base_r + 4 * m] - ackc_b[base_ack + 4 * m - 1];
            chk("t5 pending restart gap", 32'(gap), 32'd19);
        end
        repeat (200) @(posedge clk);
        #1;
        chk("t5 overrun sticky", 32'(ovr_b), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
